// File: rtl/integrator_sat.sv
// Saturating integral path: accumulate error, scale by K_i via shift-add,
// emit a clamped, right-shifted contribution with a valid/busy handshake.
module integrator_sat #(
  parameter int W     = 6,
  parameter int ACC_W = 10,
  parameter int K_W   = 6,
  parameter int OUT_W = 8,
  parameter int SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic signed [W-1:0]     e,
  input  logic                    e_valid,
  input  logic [K_W-1:0]          K_i,
  input  logic                    clr,
  input  logic                    freeze,
  output logic signed [OUT_W-1:0] i_contrib,
  output logic                    i_valid,
  output logic                    busy,
  output logic                    acc_sat,
  output logic                    overrun
);

  localparam int PW = ACC_W + K_W;
  localparam int CW = $clog2(K_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(K_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [ACC_W-1:0] esum_q, esum_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [K_W-1:0] mplier_q, mplier_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] icon_q, icon_d;
  logic ival_q, ival_d;
  logic asat_q, asat_d;
  logic ovr_q, ovr_d;

  logic [ACC_W:0] sum_w;
  logic acc_ovf;
  logic [ACC_W-1:0] acc_sat_v;
  logic [ACC_W-1:0] acc_next;
  logic [PW-1:0] shifted;
  logic [PW-OUT_W:0] hi;
  logic [OUT_W-1:0] out_sat;

  // One guard bit: overflow shows as disagreement of the top two bits
  assign sum_w = {esum_q[ACC_W-1], esum_q}
               + {{(ACC_W+1-W){e[W-1]}}, e};
  assign acc_ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign acc_sat_v = acc_ovf
    ? {sum_w[ACC_W], {(ACC_W-1){~sum_w[ACC_W]}}}
    : sum_w[ACC_W-1:0];
  assign acc_next = freeze ? esum_q : acc_sat_v;

  assign shifted = prod_q >>> SHIFT;
  assign hi = shifted[PW-1:OUT_W-1];
  assign out_sat = (&hi || !(|hi))
    ? shifted[OUT_W-1:0]
    : {shifted[PW-1], {(OUT_W-1){~shifted[PW-1]}}};

  always_comb begin
    state_d  = state_q;
    esum_d   = esum_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    icon_d   = icon_q;
    ival_d   = ival_q;
    asat_d   = asat_q;
    ovr_d    = ovr_q;
    unique case (state_q)
      IDLE: begin
        ival_d = 1'b0;
        if (e_valid && !clr) begin
          esum_d   = acc_next;
          asat_d   = !freeze && acc_ovf;
          mcand_d  = {{K_W{acc_next[ACC_W-1]}}, acc_next};
          mplier_d = K_i;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end
      end
      MULT: begin
        if (e_valid) ovr_d = 1'b1;
        // Walk the multiplier LSB-first, doubling the multiplicand
        if (mplier_q[0]) prod_d = prod_q + $signed(mcand_q);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (e_valid) ovr_d = 1'b1;
        icon_d  = out_sat;
        ival_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      esum_d = '0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      esum_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      icon_q   <= '0;
      ival_q   <= 1'b0;
      asat_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      esum_q   <= esum_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      icon_q   <= icon_d;
      ival_q   <= ival_d;
      asat_q   <= asat_d;
      ovr_q    <= ovr_d;
    end
  end

  assign i_contrib = $signed(icon_q);
  assign i_valid   = ival_q & ena;
  assign busy      = (state_q != IDLE);
  assign acc_sat   = asat_q;
  assign overrun   = ovr_q;

endmodule
